// File: rtl/irq_ctrl.sv
// irq_ctrl: fixed-priority interrupt controller with per-source mask and edge/level mode,
// register window behind the Bridge and a request/ack/EOI handshake to the CPU.
module irq_ctrl #(
    parameter int N_SRC = 6,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] hw_src,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      din,
    output logic [31:0]      dout,
    input  logic             int_ack,
    output logic             irq,
    output logic [ID_W-1:0]  irq_id
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t           r_state;
    logic [N_SRC-1:0] r_mask, r_mode, r_pend, r_src_q;
    logic [ID_W-1:0]  r_irq_id;
    logic             r_irq;
    logic [N_SRC-1:0] w_elig, w_rise, w_w1c, w_ack_clr, w_pend_nxt;
    logic [ID_W-1:0]  w_win;
    logic             w_eoi;

    assign w_elig     = r_pend & r_mask;
    assign w_rise     = hw_src & ~r_src_q;
    assign w_w1c      = (we && addr == 2'd1) ? din[N_SRC-1:0] : '0;
    assign w_ack_clr  = (r_state == REQ && int_ack) ? N_SRC'(1) << r_irq_id : '0;
    // a fresh rise always wins over a clear hitting the same edge bit
    assign w_pend_nxt = (r_mode & (w_rise | (r_pend & ~w_w1c & ~w_ack_clr))) | (~r_mode & hw_src);
    assign w_eoi      = we && addr == 2'd3;

    always_comb begin
        w_win = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (w_elig[i]) w_win = ID_W'(i);
    end

    assign dout   = addr == 2'd0 ? 32'(r_mask) :
                    addr == 2'd1 ? 32'(r_pend) :
                    addr == 2'd2 ? 32'(r_mode) :
                    {27'b0, r_state == SERVICE, r_state == REQ, 3'(r_irq_id)};
    assign irq    = r_irq;
    assign irq_id = r_irq_id;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mask   <= '0;
            r_mode   <= '0;
            r_pend   <= '0;
            r_src_q  <= '0;
            r_state  <= IDLE;
            r_irq    <= 1'b0;
            r_irq_id <= '0;
        end else begin
            r_src_q <= hw_src;
            r_pend  <= w_pend_nxt;
            if (we && addr == 2'd0) r_mask <= din[N_SRC-1:0];
            if (we && addr == 2'd2) r_mode <= din[N_SRC-1:0];
            case (r_state)
                IDLE: if (|w_elig) begin
                    r_state  <= REQ;
                    r_irq    <= 1'b1;
                    r_irq_id <= w_win;
                end
                REQ: if (int_ack) begin
                    r_state <= SERVICE;
                    r_irq   <= 1'b0;
                end else if (!w_elig[r_irq_id]) begin
                    r_state <= IDLE;
                    r_irq   <= 1'b0;
                end else if (w_win < r_irq_id) begin
                    r_irq_id <= w_win;
                end
                default: if (w_eoi) r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed plan plus randomized traffic checked every cycle against a behavioural model.
module tb_irq_ctrl;
    logic        clk = 0, reset = 0, we = 0, int_ack = 0, irq;
    logic [5:0]  hw_src = 6'h3F;
    logic [1:0]  addr = 0;
    logic [31:0] din = 0, dout;
    logic [2:0]  irq_id;
    int          n_chk = 0, n_pass = 0;
    bit          chk_en = 0;

    logic [5:0]  m_mask = 0, m_mode = 0, m_pend = 0, m_src = 0;
    int          m_st = 0, m_id = 0;

    irq_ctrl #(.N_SRC(6), .ID_W(3)) dut (
        .clk(clk), .reset(reset), .hw_src(hw_src), .we(we), .addr(addr), .din(din),
        .dout(dout), .int_ack(int_ack), .irq(irq), .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] m_dout(input logic [1:0] a);
        case (a)
            2'd0: return {26'b0, m_mask};
            2'd1: return {26'b0, m_pend};
            2'd2: return {26'b0, m_mode};
            default: return {27'b0, m_st == 2, m_st == 1, 3'(m_id)};
        endcase
    endfunction

    // model: states 0=idle 1=request 2=service
    always @(posedge clk) begin
        logic [5:0] el, np;
        int w;
        bit rise, clr;
        if (!reset) begin
            m_mask = 0; m_mode = 0; m_pend = 0; m_src = 0; m_st = 0; m_id = 0;
        end else begin
            el = m_pend & m_mask;
            w = -1;
            for (int i = 5; i >= 0; i--) if (el[i]) w = i;
            for (int i = 0; i < 6; i++) begin
                rise = hw_src[i] && !m_src[i];
                clr = (we && addr == 1 && din[i]) || (m_st == 1 && int_ack && m_id == i);
                np[i] = !m_mode[i] ? hw_src[i] : rise ? 1'b1 : clr ? 1'b0 : m_pend[i];
            end
            if (m_st == 0) begin
                if (w >= 0) begin m_st = 1; m_id = w; end
            end else if (m_st == 1) begin
                if (int_ack) m_st = 2;
                else if (!el[m_id]) m_st = 0;
                else if (w < m_id) m_id = w;
            end else if (we && addr == 3) m_st = 0;
            if (we && addr == 0) m_mask = din[5:0];
            if (we && addr == 2) m_mode = din[5:0];
            m_pend = np;
            m_src = hw_src;
        end
    end

    always @(negedge clk) if (chk_en) begin
        check("model_irq", {31'b0, irq}, {31'b0, m_st == 1});
        check("model_id", {29'b0, irq_id}, 32'(m_id));
        check("model_dout", dout, m_dout(addr));
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        addr = a;
        #1;
        check(nm, dout, e);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; din = d; we = 1;
        step;
        we = 0;
    endtask

    initial begin
        // reset with all sources high
        step; chk_en = 1; step;
        check("t1_irq", {31'b0, irq}, 0);
        for (int a = 0; a < 4; a++) rd(2'(a), 0, "t1_dout");
        reset = 1; step; step;
        check("t1_irq_mask0", {31'b0, irq}, 0);
        hw_src = 0;
        // edge pulse on source 0, ack, EOI
        wr(2, 1); wr(0, 1);
        hw_src = 6'h01; step; hw_src = 0;
        rd(1, 1, "t2_pend");
        check("t2_irq_pre", {31'b0, irq}, 0);
        step;
        check("t2_irq", {31'b0, irq}, 1);
        check("t2_id", {29'b0, irq_id}, 0);
        int_ack = 1; step; int_ack = 0;
        check("t2_irq_ack", {31'b0, irq}, 0);
        rd(1, 0, "t2_pend_ack");
        rd(3, 32'h10, "t2_status_svc");
        wr(3, 0);
        rd(3, 0, "t2_status_eoi");
        // level mode preemption before ack
        wr(2, 0); wr(0, 7);
        hw_src = 6'h02; step; step;
        check("t3_irq", {31'b0, irq}, 1);
        check("t3_id1", {29'b0, irq_id}, 1);
        hw_src = 6'h03; step; step;
        check("t3_irq_hold", {31'b0, irq}, 1);
        check("t3_id0", {29'b0, irq_id}, 0);
        int_ack = 1; step; int_ack = 0;
        rd(3, 32'h10, "t3_svc0");
        hw_src = 6'h02;
        wr(3, 0);
        check("t3_eoi_gap", {31'b0, irq}, 0);
        step;
        check("t3_rereq", {31'b0, irq}, 1);
        check("t3_rereq_id", {29'b0, irq_id}, 1);
        hw_src = 0; step; step;
        check("t3_withdraw", {31'b0, irq}, 0);
        // level request withdrawn before ack, late ack ignored
        wr(0, 4);
        hw_src = 6'h04; step; step;
        check("t4_irq", {31'b0, irq}, 1);
        check("t4_id", {29'b0, irq_id}, 2);
        hw_src = 0; step; step;
        check("t4_fall", {31'b0, irq}, 0);
        int_ack = 1; step; int_ack = 0;
        rd(3, 32'h02, "t4_ack_ignored");
        // edge set beats W1C and ack clear
        wr(2, 2); wr(0, 2);
        hw_src = 6'h02; step; hw_src = 0; step;
        hw_src = 6'h02; wr(1, 2); hw_src = 0;
        rd(1, 2, "t5_w1c_collide");
        step;
        hw_src = 6'h02; int_ack = 1; step; int_ack = 0; hw_src = 0;
        rd(1, 2, "t5_ack_collide");
        rd(3, 32'h11, "t5_svc1");
        // reset during service with ack and write
        reset = 0; int_ack = 1; we = 1; addr = 3; din = 32'hFF;
        step;
        reset = 1; int_ack = 0; we = 0;
        check("t6_irq", {31'b0, irq}, 0);
        check("t6_id", {29'b0, irq_id}, 0);
        for (int a = 0; a < 4; a++) rd(2'(a), 0, "t6_dout");
        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) hw_src = hw_src ^ 6'(1 << $urandom_range(0, 5));
            we = $urandom_range(0, 7) == 0;
            addr = 2'($urandom_range(0, 3));
            din = $urandom;
            int_ack = $urandom_range(0, 3) == 0;
            reset = $urandom_range(0, 299) != 0;
            step;
        end
        reset = 1; we = 0; int_ack = 0;
        step;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Programmable interrupt controller between the interrupt sources (TC0 IRQ, TC1 IRQ, external interrupt, spare lines) and the processor's interrupt input.
- Latches per-source pending state, applies a mask and a per-source edge/level mode, and arbitrates by fixed priority (lowest index wins).
- Presents one request plus its source ID to the CPU and runs a request/acknowledge/end-of-interrupt handshake.
- Its registers are mapped behind the Bridge like the timers: word-addressed, with a write enable decoded by the Bridge.

Parameters:
N_SRC, 6, number of interrupt sources; valid range 1..8; matches the 6-bit HWInt vector.
ID_W, 3, width of irq_id; must satisfy 2^ID_W >= N_SRC.

Ports:
clk  input  1  system clock.
reset  input  1  synchronous reset, active-low: 0 = reset, sampled on the rising edge of clk.
hw_src  input  N_SRC  raw interrupt lines; bit 0 = TC0, bit 1 = TC1, bit 2 = external.
we  input  1  register write strobe from the Bridge.
addr  input  2  word index, equal to the Bridge address bits [3:2].
din  input  32  write data.
dout  output  32  read data; combinational from addr.
int_ack  input  1  one-cycle pulse from the CPU when it takes the interrupt.
irq  output  1  interrupt request to the CPU.
irq_id  output  ID_W  ID of the source being requested or serviced.

Behaviour:
- Registers, with N_SRC-bit fields zero-extended to 32 bits:
  - 0 MASK (R/W): 1 = enabled.
  - 1 PENDING (R; W1C on edge-mode bits only).
  - 2 MODE (R/W): 1 = edge, 0 = level.
  - 3 STATUS: read gives {27'b0, state==SERVICE, state==REQ, zero-extended irq_id}; any write is EOI.
- Reset (reset==0 at a clock edge): MASK=0, MODE=0, PENDING=0, src_q=0, state=IDLE, irq=0, irq_id=0, so dout reads 0 at every address.
  - Reset applied mid-REQ or mid-SERVICE returns to IDLE on that edge; an int_ack or we in the same cycle is ignored.
- Source capture: src_q <= hw_src every cycle; rise = hw_src & ~src_q.
  - Edge bit: PENDING[i] is set on rise[i] and cleared by W1C or by ack.
  - Level bit: PENDING[i] <= hw_src[i] every cycle; W1C and ack have no effect on it.
- Conflicts on the same bit in the same cycle: set (rise) beats W1C clear, and set beats ack clear.
- Arbitration: elig = PENDING & MASK; winner = lowest set index of elig.
- FSM:
  - IDLE: irq=0. If elig != 0, go to REQ and latch irq_id = winner.
  - REQ: irq=1.
    - If int_ack: go to SERVICE and clear the edge PENDING bit of irq_id on the same edge.
    - Else if elig == 0 or elig[irq_id] == 0: go to IDLE (request withdrawn; irq falls next cycle).
    - Else if winner < irq_id: re-latch irq_id = winner and stay in REQ (preemption before ack).
    - int_ack takes precedence over withdrawal in the same cycle.
  - SERVICE: irq=0; irq_id holds. An EOI write (we && addr==3) returns to IDLE. Arbitration resumes from IDLE, so the earliest irq reassertion is 2 cycles after EOI.
  - int_ack outside REQ is ignored.
- Latency: hw_src rises before edge k → PENDING set at edge k → REQ/irq=1 after edge k+1. Level mode has the same timing.
- MASK and MODE writes take effect on the following edge. Changing MODE does not alter the current PENDING contents.
- din bits above N_SRC are ignored; unused irq_id codes are never produced.

Test Plan:
1. Reset low for 2 cycles with hw_src=6'h3F → irq=0, dout=0 at all addresses; after reset release with MASK=0 → irq remains 0.
2. MODE=0x01, MASK=0x01; pulse hw_src[0] for 1 cycle → PENDING=0x01 at edge k, irq=1 and irq_id=0 after edge k+1; int_ack → irq=0, PENDING=0, STATUS=0x10; EOI write → STATUS=0x00.
3. MASK=0x07, level mode; hold hw_src[1] → REQ with id=1; then raise hw_src[0] → irq_id becomes 0 with irq held at 1; ack → SERVICE id=0; EOI → REQ again with id=1 two cycles later.
4. Level mode, MASK=0x04; assert hw_src[2], then drop it before ack → state returns to IDLE and irq falls; an int_ack arriving afterwards is ignored.
5. Edge mode bit 1; W1C write of 0x02 in the same cycle as a fresh rise on hw_src[1] → PENDING[1] stays 1. Repeat with int_ack colliding with a new rise → PENDING[1] stays 1.
6. Drive reset low while in SERVICE with int_ack=1 and we=1 → next cycle state=IDLE, all registers 0, irq=0.
